// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//
// Boot stage for the 16-bit pipelined core. A program image arrives as a byte
// stream, is packed into 16-bit instruction words and written through the
// instruction memory write port. The core is held in reset until the image
// checksum has been verified.
//
// Stream format:
//   LEN_HI, LEN_LO (N = word count), 2*N payload bytes (high byte first),
//   CSUM. An image is good when the XOR of every byte, LEN and CSUM
//   included, is zero.
//
// Handshake:
//   A byte moves only in a cycle where in_valid and in_ready are both high.
//   in_ready is registered. While the loader is in RUN or ERR, in_ready is
//   low, so the stream is held back rather than dropped. Nothing in the
//   loader changes state in a cycle without a transfer.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   reset        synchronous active-high reset; overrides every other input
//   in_data      stream byte
//   in_valid     in_data is valid this cycle
//   in_ready     loader can accept a byte this cycle
//   reload       one-cycle pulse that restarts loading from RUN or ERR
//   mem_we       instruction memory write strobe (one-cycle pulse)
//   mem_addr     byte address of the write (2 * word index, always even)
//   mem_wdata    instruction word {first byte, second byte}
//   cpu_reset    core reset; high while loading or after an error
//   done         image loaded and verified; core released
//   error        length overflow or checksum mismatch
//   words_loaded number of words written during the current load
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH = 128,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          reload,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    output logic          cpu_reset,
    output logic          done,
    output logic          error,
    output logic [7:0]    words_loaded
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_D_HI,
        S_D_LO,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t      state;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [7:0]  hi_byte;
    logic [7:0]  acc;

    logic        xfer;
    logic [7:0]  acc_next;
    logic [15:0] len_next;
    logic [15:0] words_next;

    assign xfer       = in_valid & in_ready;
    assign acc_next   = acc ^ in_data;
    assign len_next   = {len_hi, in_data};
    assign words_next = {8'd0, words_loaded} + 16'd1;

    // words_loaded doubles as the write index. It is cleared whenever a new
    // load starts and stops at N, and N never exceeds DEPTH, so the address
    // cannot wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_LEN_HI;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 16'h0000;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 8'd0;
            acc          <= 8'h00;
            len_hi       <= 8'h00;
            len          <= 16'h0000;
            hi_byte      <= 8'h00;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_LEN_HI: begin
                    // Raising in_ready here makes it rise the cycle after
                    // reset drops.
                    in_ready <= 1'b1;
                    if (xfer) begin
                        len_hi <= in_data;
                        acc    <= acc_next;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        acc <= acc_next;
                        len <= len_next;
                        if (len_next > DEPTH_W) begin
                            // Oversized image: reject before any write.
                            state    <= S_ERR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (len_next == 16'h0000) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_D_HI;
                        end
                    end
                end
                S_D_HI: begin
                    if (xfer) begin
                        hi_byte <= in_data;
                        acc     <= acc_next;
                        state   <= S_D_LO;
                    end
                end
                S_D_LO: begin
                    if (xfer) begin
                        acc          <= acc_next;
                        mem_we       <= 1'b1;
                        mem_wdata    <= {hi_byte, in_data};
                        mem_addr     <= AW'({words_loaded, 1'b0});
                        words_loaded <= words_next[7:0];
                        state        <= (words_next == len) ? S_CSUM : S_D_HI;
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        acc      <= acc_next;
                        in_ready <= 1'b0;
                        if (acc_next == 8'h00) begin
                            state     <= S_RUN;
                            cpu_reset <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                S_RUN, S_ERR: begin
                    if (reload) begin
                        state        <= S_LEN_HI;
                        in_ready     <= 1'b1;
                        cpu_reset    <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= 8'd0;
                        acc          <= 8'h00;
                    end
                end
                default: begin
                    state    <= S_LEN_HI;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
//
// Table-driven bench for imem_loader. Every row of the vector table is one
// image: its word count, stall pattern, checksum corruption and the final
// done/error/words_loaded it must end with. Expected memory writes are queued
// as payload bytes are driven. They are popped and compared as mem_we pulses
// appear. Hand-written sequences cover reset, back-pressure in ERR, reload
// while loading and reset in the middle of a load.
// ----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int DEPTH = 128;
    localparam int AW    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          reload;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;
    logic [7:0]    words_loaded;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .reload       (reload),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          checks    = 0;
    int          failures  = 0;
    int          wr_count  = 0;
    logic        prev_we   = 1'b0;
    logic [31:0] exp_q[$];
    logic [15:0] pl [0:255];

    typedef struct {
        int         n;
        bit         fixed;
        bit         stall;
        bit         bad;
        logic       exp_done;
        logic       exp_err;
        logic [7:0] exp_words;
    } vec_t;

    vec_t vecs [0:7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance one cycle and sample just after the edge. Any write strobe is
    // matched against the head of the expected queue.
    task automatic tick();
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (mem_we) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h required=none", {mem_addr, mem_wdata});
            end else begin
                e = exp_q.pop_front();
                check("mem_write", {mem_addr, mem_wdata}, e);
            end
            check("we_back_to_back", prev_we, 1'b0);
        end
        prev_we = mem_we;
    endtask

    // ---------------- driver ----------------
    task automatic send_byte(input logic [7:0] b, input bit stall);
        int n = 0;
        if (stall) begin
            in_valid = 1'b0;
            tick();
        end
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) check("ready_timeout", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_image(input int n, input bit stall, input bit bad);
        logic [15:0] nn;
        logic [7:0]  cs;
        nn = 16'(n);
        cs = nn[15:8] ^ nn[7:0];
        for (int i = 0; i < n && i < 256; i++) cs = cs ^ pl[i][15:8] ^ pl[i][7:0];
        if (bad) cs = cs ^ 8'h01;
        send_byte(nn[15:8], stall);
        send_byte(nn[7:0], stall);
        if (n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                send_byte(pl[i][15:8], stall);
                exp_q.push_back({16'(2 * i), pl[i]});
                send_byte(pl[i][7:0], stall);
            end
            send_byte(cs, stall);
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        // {cpu_reset, done, error, in_ready, words_loaded}
        check("reload_clear", {cpu_reset, done, error, in_ready, words_loaded},
              {1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
    endtask

    // ---------------- test ----------------
    initial begin
        int w0;
        bit need_reload;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;

        //            n    fixed stall bad  done err  words
        vecs[0] = '{  2,   1,    0,    0,   1'b1, 1'b0, 8'd2  };
        vecs[1] = '{  2,   1,    1,    0,   1'b1, 1'b0, 8'd2  };
        vecs[2] = '{  2,   1,    0,    1,   1'b0, 1'b1, 8'd2  };
        vecs[3] = '{  3,   0,    0,    0,   1'b1, 1'b0, 8'd3  };
        vecs[4] = '{129,   0,    0,    0,   1'b0, 1'b1, 8'd0  };
        vecs[5] = '{  0,   0,    1,    0,   1'b1, 1'b0, 8'd0  };
        vecs[6] = '{128,   0,    0,    0,   1'b1, 1'b0, 8'd128};
        vecs[7] = '{  5,   0,    1,    1,   1'b0, 1'b1, 8'd5  };

        // Reset values, then in_ready rises one cycle after reset drops.
        repeat (3) tick();
        check("reset_state",
              {in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error, words_loaded},
              {1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0});
        reset = 1'b0;
        tick();
        check("ready_after_reset", in_ready, 1'b1);

        need_reload = 1'b0;
        for (int v = 0; v < 8; v++) begin
            if (need_reload) pulse_reload();
            if (vecs[v].fixed) begin
                pl[0] = 16'h1234;
                pl[1] = 16'h5678;
            end else begin
                for (int i = 0; i < 256; i++) pl[i] = 16'($urandom_range(0, 65535));
            end
            w0 = wr_count;
            send_image(vecs[v].n, vecs[v].stall, vecs[v].bad);
            // {done, error, cpu_reset, in_ready, words_loaded} right after the last transfer
            check($sformatf("vec%0d_status", v),
                  {done, error, cpu_reset, in_ready, words_loaded},
                  {vecs[v].exp_done, vecs[v].exp_err, ~vecs[v].exp_done, 1'b0, vecs[v].exp_words});
            check($sformatf("vec%0d_write_count", v), 64'(wr_count - w0), 64'(vecs[v].exp_words));
            check($sformatf("vec%0d_pending", v), 64'(exp_q.size()), 64'd0);
            need_reload = 1'b1;
        end

        // ERR holds the stream back: no acceptance, nothing changes.
        in_data  = 8'hAA;
        in_valid = 1'b1;
        repeat (4) tick();
        check("err_backpressure", {in_ready, error, cpu_reset, words_loaded},
              {1'b0, 1'b1, 1'b1, 8'd5});
        in_valid = 1'b0;

        // Reload during loading is ignored; reset in the middle of a load.
        pulse_reload();
        for (int i = 0; i < 3; i++) pl[i] = 16'($urandom_range(0, 65535));
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("reload_ignored", {in_ready, cpu_reset, done, error, words_loaded},
              {1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        send_byte(pl[0][15:8], 1'b0);
        exp_q.push_back({16'h0000, pl[0]});
        send_byte(pl[0][7:0], 1'b0);
        check("first_word_count", words_loaded, 8'd1);
        reset  = 1'b1;
        reload = 1'b1;
        tick();
        reset  = 1'b0;
        reload = 1'b0;
        check("midload_reset",
              {in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error, words_loaded},
              {1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0});
        tick();
        check("ready_after_midload_reset", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) pl[i] = 16'($urandom_range(0, 65535));
        send_image(3, 1'b0, 1'b0);
        check("reload_after_reset_status", {done, error, cpu_reset, words_loaded},
              {1'b1, 1'b0, 1'b0, 8'd3});
        check("reload_after_reset_pending", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
